// File: rtl/video_pkg.sv
// video_pkg: shared 1080p60 timing constants, pattern encoding and colour tables
// for the video test-pattern source.
package video_pkg;

    localparam int H_ACTIVE_1080P = 1920;
    localparam int H_FP_1080P     = 88;
    localparam int H_SYNC_1080P   = 44;
    localparam int H_BP_1080P     = 148;
    localparam int V_ACTIVE_1080P = 1080;
    localparam int V_FP_1080P     = 4;
    localparam int V_SYNC_1080P   = 5;
    localparam int V_BP_1080P     = 36;
    localparam int CELL_PITCH     = 24;

    // Counter widths cover the 1080p totals; the ramp pattern needs h bits [10:3].
    localparam int HW = 12;
    localparam int VW = 11;
    localparam int CW = 8;

    localparam int BAR_W    = 32;
    localparam int BAR_STEP = 8;

    typedef enum logic [1:0] {PAT_BARS, PAT_GRID, PAT_RAMP, PAT_SOLID} pattern_t;
    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    localparam logic [23:0] WHITE        = 24'hFFFFFF;
    localparam logic [23:0] BG_DARK_BLUE = 24'h001020;

    // Index 0 is the leftmost bar.
    localparam logic [7:0][23:0] BAR_RGB = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };

    function automatic logic in_span(input int x, input int lo, input int len);
        return x >= lo && x < lo + len;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if: raster video stream from the timing generator to a video sink.
interface video_timing_gen_if;
    logic [23:0] vid_rgb;
    logic [1:0]  vh_blank;
    logic [2:0]  dvh_sync;
    logic        sof;
    logic [15:0] frame_cnt;

    modport master (output vid_rgb, vh_blank, dvh_sync, sof, frame_cnt);
    modport slave  (input  vid_rgb, vh_blank, dvh_sync, sof, frame_cnt);
endinterface

// File: rtl/video_pattern_gen.sv
// video_pattern_gen: combinational test-pattern colour for the current raster position.
// VIDEO_TPG_MOVING_BAR_EN adds a white moving vertical bar over patterns 0-2.
module video_pattern_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_1080P
) (
    input  logic [HW-1:0] h,
    input  logic [CW-1:0] cell_x,
    input  logic [CW-1:0] cell_y,
    input  pattern_t      pat,
    input  logic [23:0]   solid,
`ifdef VIDEO_TPG_MOVING_BAR_EN
    input  logic [HW-1:0] bar_x,
`endif
    output logic [23:0]   rgb
);

    logic [2:0]  bar_idx;
    logic [23:0] base;

    // Threshold compare chain instead of a divider for the bar index.
    always_comb begin
        bar_idx = '0;
        for (int i = 1; i < 8; i++)
            if (int'(h) >= i * (H_ACTIVE / 8)) bar_idx = 3'(i);
        base = pat == PAT_BARS ? BAR_RGB[bar_idx] :
               pat == PAT_GRID ? ((cell_x == '0 || cell_y == '0) ? WHITE : BG_DARK_BLUE) :
               pat == PAT_RAMP ? {3{h[10:3]}} : solid;
`ifdef VIDEO_TPG_MOVING_BAR_EN
        rgb = (pat != PAT_SOLID && in_span(int'(h), int'(bar_x), BAR_W)) ? WHITE : base;
`else
        rgb = base;
`endif
    end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: 1080p60 raster timing and test-pattern source with frame-aligned start/stop.
// Define VIDEO_TPG_MOVING_BAR_EN to enable the moving white bar overlay.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_1080P,
    parameter int   H_FP     = H_FP_1080P,
    parameter int   H_SYNC   = H_SYNC_1080P,
    parameter int   H_BP     = H_BP_1080P,
    parameter int   V_ACTIVE = V_ACTIVE_1080P,
    parameter int   V_FP     = V_FP_1080P,
    parameter int   V_SYNC   = V_SYNC_1080P,
    parameter int   V_BP     = V_BP_1080P,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    parameter int   CELL     = CELL_PITCH
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cen_i,
    input  logic               en_i,
    input  logic [1:0]         pat_sel_i,
    input  logic [23:0]        solid_rgb_i,
    video_timing_gen_if.master vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    state_t        state, nxt;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [CW-1:0] cell_x, cell_y;
    pattern_t      pat_q, pat_cur;
    logic [23:0]   solid_q, solid_cur, pix;
    logic          run, adv, first, last_h, last_v, frame_end;
    logic          hb, vb, de, hs, vs;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) state <= ST_IDLE;
        else if (cen_i) state <= nxt;

    // A stop request is only honoured on the last pixel, so frames always complete.
    always_comb
        nxt = state == ST_IDLE ? (en_i ? ST_RUN : ST_IDLE) :
              (last_h && last_v && !en_i) ? ST_IDLE : ST_RUN;

    always_comb begin
        run       = state == ST_RUN;
        adv       = cen_i && run;
        frame_end = adv && last_h && last_v;
    end

    always_comb begin
        last_h    = int'(h_cnt) == H_TOTAL - 1;
        last_v    = int'(v_cnt) == V_TOTAL - 1;
        first     = h_cnt == '0 && v_cnt == '0;
        hb        = int'(h_cnt) >= H_ACTIVE;
        vb        = int'(v_cnt) >= V_ACTIVE;
        de        = !hb && !vb;
        hs        = in_span(int'(h_cnt), H_ACTIVE + H_FP, H_SYNC);
        vs        = in_span(int'(v_cnt), V_ACTIVE + V_FP, V_SYNC);
        pat_cur   = first ? pattern_t'(pat_sel_i) : pat_q;
        solid_cur = first ? solid_rgb_i : solid_q;
    end

    // Cell counters run alongside h/v so the grid needs no modulo hardware.
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            cell_x  <= '0;
            cell_y  <= '0;
            pat_q   <= PAT_BARS;
            solid_q <= '0;
        end else if (adv) begin
            h_cnt  <= last_h ? '0 : h_cnt + HW'(1);
            cell_x <= (last_h || int'(cell_x) == CELL - 1) ? '0 : cell_x + CW'(1);
            if (last_h) begin
                v_cnt  <= last_v ? '0 : v_cnt + VW'(1);
                cell_y <= (last_v || int'(cell_y) == CELL - 1) ? '0 : cell_y + CW'(1);
            end
            if (first) begin
                pat_q   <= pat_cur;
                solid_q <= solid_cur;
            end
        end

`ifdef VIDEO_TPG_MOVING_BAR_EN
    logic [HW-1:0] bar_x;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) bar_x <= '0;
        else if (frame_end) bar_x <= int'(bar_x) + BAR_STEP >= H_ACTIVE ? '0 : bar_x + HW'(BAR_STEP);
`endif

    video_pattern_gen #(.H_ACTIVE(H_ACTIVE)) u_pat (
        .h      (h_cnt),
        .cell_x (cell_x),
        .cell_y (cell_y),
        .pat    (pat_cur),
        .solid  (solid_cur),
`ifdef VIDEO_TPG_MOVING_BAR_EN
        .bar_x  (bar_x),
`endif
        .rgb    (pix)
    );

    // In IDLE the registers are reloaded with their reset values; frame_cnt is kept.
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            vid.vid_rgb   <= '0;
            vid.vh_blank  <= 2'b11;
            vid.dvh_sync  <= {1'b0, ~VS_POL, ~HS_POL};
            vid.sof       <= 1'b0;
            vid.frame_cnt <= '0;
        end else if (cen_i) begin
            vid.vid_rgb  <= (run && de) ? pix : '0;
            vid.vh_blank <= run ? {vb, hb} : 2'b11;
            vid.dvh_sync <= {run && de, (run && vs) ? VS_POL : ~VS_POL, (run && hs) ? HS_POL : ~HS_POL};
            vid.sof      <= run && first;
            if (frame_end) vid.frame_cnt <= vid.frame_cnt + 16'd1;
        end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: randomized scoreboard bench; a pixel-index reference model predicts
// every output cycle on a reduced raster so several frames fit in a short run.
module tb_video_timing_gen;

    localparam int HA = 64, HF = 4, HS = 4, HBP = 8;
    localparam int VA = 12, VF = 2, VS = 2, VBP = 2;
    localparam int CELL = 6;
    localparam int HT = HA + HF + HS + HBP;
    localparam int VT = VA + VF + VS + VBP;
    localparam int FT = HT * VT;

    typedef struct packed {
        logic [23:0] rgb;
        logic [1:0]  vhb;
        logic [2:0]  sync;
        logic        sof;
        logic [15:0] fc;
    } vout_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  pat = 2'd0;
    logic [23:0] solid = 24'd0;
    int          cen_mode = 0;
    int          checks = 0;
    int          errors = 0;

    video_timing_gen_if vif ();

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VBP), .CELL(CELL)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cen_i       (cen),
        .en_i        (en),
        .pat_sel_i   (pat),
        .solid_rgb_i (solid),
        .vid         (vif)
    );

    always #5 clk = ~clk;

    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    function automatic vout_t idle_out(input logic [15:0] fc);
        return '{rgb: 24'h0, vhb: 2'b11, sync: 3'b000, sof: 1'b0, fc: fc};
    endfunction

    // Output for pixel index p of a frame, derived directly from the raster rules.
    function automatic logic [28:0] pix_out(input int p, input int pt, input logic [23:0] sol, input int bar);
        int h, v;
        logic de;
        logic [23:0] c;
        h  = p % HT;
        v  = p / HT;
        de = h < HA && v < VA;
        case (pt)
            0:       c = bars[h / (HA / 8)];
            1:       c = (h % CELL == 0 || v % CELL == 0) ? 24'hFFFFFF : 24'h001020;
            2:       c = {3{8'(h >> 3)}};
            default: c = sol;
        endcase
`ifdef VIDEO_TPG_MOVING_BAR_EN
        if (pt != 3 && h >= bar && h < bar + 32) c = 24'hFFFFFF;
`else
        if (bar < 0) c = 24'h0;
`endif
        return {de ? c : 24'h0, v >= VA, h >= HA, de,
                v >= VA + VF && v < VA + VF + VS, h >= HA + HF && h < HA + HF + HS};
    endfunction

    vout_t       q[$];
    vout_t       prev;
    bit          running;
    int          p, pat_l, barx;
    logic [23:0] sol_l;
    logic [15:0] fc;

    always @(posedge clk) begin
        if (rst) begin
            running = 0; p = 0; fc = 0; barx = 0; pat_l = 0; sol_l = 0;
            prev = idle_out(16'd0);
        end else if (cen) begin
            if (!running) begin
                prev = idle_out(fc);
                running = en;
            end else begin
                if (p == 0) begin
                    pat_l = int'(pat);
                    sol_l = solid;
                end
                {prev.rgb, prev.vhb, prev.sync} = pix_out(p, pat_l, sol_l, barx);
                prev.sof = p == 0;
                if (p == FT - 1) begin
                    fc++;
                    barx = barx + 8 >= HA ? 0 : barx + 8;
                    if (!en) running = 0;
                end
                prev.fc = fc;
                p = (p + 1) % FT;
            end
        end
        q.push_back(prev);
    end

    function automatic vout_t dut_out();
        return {vif.vid_rgb, vif.vh_blank, vif.dvh_sync, vif.sof, vif.frame_cnt};
    endfunction

    always @(negedge clk) begin
        vout_t e, a;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = dut_out();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL scoreboard t=%0t got rgb=%h vhb=%b sync=%b sof=%b fc=%0d want rgb=%h vhb=%b sync=%b sof=%b fc=%0d",
                         $time, a.rgb, a.vhb, a.sync, a.sof, a.fc, e.rgb, e.vhb, e.sync, e.sof, e.fc);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        cen = cen_mode == 0 ? 1'b1 : cen_mode == 1 ? ~cen : 1'($urandom_range(0, 1));
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset(input string name);
        vout_t a;
        a = dut_out();
        checks++;
        if (a !== idle_out(16'd0)) begin
            errors++;
            $display("FAIL %s got %h want %h", name, a, idle_out(16'd0));
        end
    endtask

    initial begin
        cycles(3);
        #1 chk_reset("reset_state");
        cycles(1);
        rst = 0;
        en  = 1;
        cycles(700);
        pat = 2'd2;
        cycles(2 * FT);
        pat = 2'd1;
        cycles(FT);
        pat = 2'd3;
        solid = $urandom;
        cycles(FT);
        cen_mode = 1;
        pat = 2'd0;
        cycles(FT);
        en = 0;
        cycles(2 * FT + 200);
        for (int i = 0; i < 6; i++) begin
            cen_mode = $urandom_range(0, 2);
            en = 1;
            pat = 2'($urandom_range(0, 3));
            solid = $urandom;
            cycles($urandom_range(FT / 2, 2 * FT));
            pat = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) en = 0;
            cycles($urandom_range(FT / 4, FT));
        end
        cen_mode = 0;
        en = 1;
        cycles(FT + 300);
        #3 rst = 1;
        #1 chk_reset("async_reset");
        cycles(3);
        rst = 0;
        cycles(FT + 40);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
